sd_image_loader: RTL and testbench

Sequences the loading of one full image from the SD card into the frame buffer. It computes the image's starting sector and issues one 512-byte sector read per request to the SD controller. It packs the returned RGB888 byte stream into RGB332 pixels and drives the frame buffer write port. It sits between the top-level display state machine (load_start/done) and the SD controller and frame buffer.

---
 rtl/sd_image_loader_if.sv | 23 ++
 rtl/sd_image_loader.sv | 207 ++++++++++++++++++++
 tb/tb_sd_image_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_image_loader_if.sv
// SD-controller and frame-buffer signal bundle for the image loader.
// master = loader side, slave = SD controller / frame buffer side.
interface sd_image_loader_if;
    logic        sd_start;
    logic [31:0] sd_sector;
    logic        sd_busy;
    logic [7:0]  sd_data;
    logic        sd_valid;
    logic        sd_sector_done;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;

    modport master (
        output sd_start, sd_sector, fb_we, fb_addr, fb_data,
        input  sd_busy, sd_data, sd_valid, sd_sector_done
    );

    modport slave (
        input  sd_start, sd_sector, fb_we, fb_addr, fb_data,
        output sd_busy, sd_data, sd_valid, sd_sector_done
    );
endinterface

// File: rtl/sd_image_loader.sv
// Loads one image from SD sectors into the frame buffer,
// packing the RGB888 byte stream into RGB332 pixels.
module sd_image_loader #(
    parameter int IMG_W           = 320,
    parameter int IMG_H           = 240,
    parameter int SECTOR_BYTES    = 512,
    parameter int SECTORS_PER_IMG = 450,
    parameter int BASE_SECTOR     = 0,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_start,
    input  logic [7:0] image_index,
    output logic       busy,
    output logic       done,
    output logic       error,
    sd_image_loader_if.master bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int BCW  = $clog2(SECTOR_BYTES + 1);
    localparam int SCW  = $clog2(SECTORS_PER_IMG + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_DATA, NEXT, FINISH, FAIL
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           start_q, start_d;
    logic [31:0]    sector_q, sector_d;
    logic           we_q, we_d;
    logic [16:0]    addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic [SCW-1:0] sec_cnt_q, sec_cnt_d;
    logic [BCW-1:0] byte_q, byte_d;
    logic [16:0]    pix_q, pix_d;
    logic           full_q, full_d;
    logic [1:0]     phase_q, phase_d;
    logic [2:0]     r_q, r_d;
    logic [2:0]     g_q, g_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    // Only the top bits of each colour byte survive RGB332 packing.
    logic unused_data;
    assign unused_data = ^bus.sd_data[4:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            start_q   <= 1'b0;
            sector_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            sec_cnt_q <= '0;
            byte_q    <= '0;
            pix_q     <= '0;
            full_q    <= 1'b0;
            phase_q   <= '0;
            r_q       <= '0;
            g_q       <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            start_q   <= start_d;
            sector_q  <= sector_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sec_cnt_q <= sec_cnt_d;
            byte_q    <= byte_d;
            pix_q     <= pix_d;
            full_q    <= full_d;
            phase_q   <= phase_d;
            r_q       <= r_d;
            g_q       <= g_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        start_d   = 1'b0;
        sector_d  = sector_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        sec_cnt_d = sec_cnt_q;
        byte_d    = byte_q;
        pix_d     = pix_q;
        full_d    = full_q;
        phase_d   = phase_q;
        r_d       = r_q;
        g_d       = g_q;
        tmo_d     = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    sector_d  = 32'(BASE_SECTOR)
                              + 32'(image_index) * 32'(SECTORS_PER_IMG);
                    sec_cnt_d = '0;
                    byte_d    = '0;
                    pix_d     = '0;
                    full_d    = 1'b0;
                    phase_d   = '0;
                    error_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d = '0;
                if (!bus.sd_busy) begin
                    start_d = 1'b1;
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.sd_valid) begin
                    tmo_d  = '0;
                    byte_d = byte_q + 1'b1;
                    unique case (phase_q)
                        2'd0: begin
                            r_d     = bus.sd_data[7:5];
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            g_d     = bus.sd_data[7:5];
                            phase_d = 2'd2;
                        end
                        default: begin
                            phase_d = 2'd0;
                            // Bytes past the final pixel are dropped.
                            if (!full_q) begin
                                we_d   = 1'b1;
                                addr_d = pix_q;
                                data_d = {r_q, g_q, bus.sd_data[7:6]};
                                if (pix_q == 17'(NPIX - 1)) begin
                                    full_d = 1'b1;
                                end else begin
                                    pix_d = pix_q + 1'b1;
                                end
                            end
                        end
                    endcase
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
                        state_d = FAIL;
                    end
                end
                if (bus.sd_sector_done) begin
                    state_d = (byte_d == BCW'(SECTOR_BYTES)) ? NEXT : FAIL;
                end
                if (state_d == FAIL) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            NEXT: begin
                sec_cnt_d = sec_cnt_q + 1'b1;
                byte_d    = '0;
                if (sec_cnt_d == SCW'(SECTORS_PER_IMG)) begin
                    state_d = FINISH;
                end else begin
                    sector_d = sector_q + 1'b1;
                    state_d  = ISSUE;
                end
            end
            FINISH: begin
                if (!we_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            FAIL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign bus.sd_start  = start_q;
    assign bus.sd_sector = sector_q;
    assign bus.fb_we     = we_q;
    assign bus.fb_addr   = addr_q;
    assign bus.fb_data   = data_q;
endmodule

// File: tb/tb_sd_image_loader.sv
// Randomised scoreboard bench for sd_image_loader with a small
// 32x32 image (6 sectors of 512 bytes) and a 50-cycle timeout.
module tb_sd_image_loader;
    localparam int W    = 32;
    localparam int H    = 32;
    localparam int SB   = 512;
    localparam int SPI  = 6;
    localparam int BASE = 100;
    localparam int TMO  = 50;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic [7:0] image_index;
    logic       busy, done, error;

    sd_image_loader_if bus();

    sd_image_loader #(
        .IMG_W(W), .IMG_H(H), .SECTOR_BYTES(SB),
        .SECTORS_PER_IMG(SPI), .BASE_SECTOR(BASE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .image_index(image_index),
        .busy(busy), .done(done), .error(error),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int last_addr = -1;
    int gbyte;
    logic [7:0]  img [0:NPIX*3-1];
    logic [7:0]  fb_mem [0:NPIX-1];
    int          exp_sec_q [$];
    logic [24:0] exp_pix_q [$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request.
    always @(negedge clk) begin
        if (bus.sd_start) begin
            if (exp_sec_q.size() == 0)
                check("unexpected_sd_start", bus.sd_sector, 32'hFFFF_FFFF);
            else
                check("sd_sector", bus.sd_sector, exp_sec_q.pop_front());
        end
        if (bus.fb_we) begin
            wr_cnt++;
            last_addr = int'(bus.fb_addr);
            fb_mem[bus.fb_addr] = bus.fb_data;
            if (exp_pix_q.size() == 0)
                check("unexpected_fb_we", {15'd0, bus.fb_addr}, 32'hFFFF_FFFF);
            else
                check("fb_write", {7'd0, bus.fb_addr, bus.fb_data},
                      {7'd0, exp_pix_q.pop_front()});
        end
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", {31'd0, busy}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: pixel k is bytes 3k..3k+2, packed R[7:5] G[7:5] B[7:6].
    task automatic drive_byte(input logic [7:0] b, input bit last);
        bit same;
        logic [7:0] r, g;
        same = ($urandom_range(0, 1) == 1);
        repeat ($urandom_range(0, 2)) step();
        bus.sd_data = b;
        bus.sd_valid = 1'b1;
        bus.sd_sector_done = last && same;
        if (gbyte % 3 == 2 && gbyte / 3 < NPIX) begin
            r = img[gbyte-2];
            g = img[gbyte-1];
            exp_pix_q.push_back({17'(gbyte / 3), r[7:5], g[7:5], b[7:6]});
        end
        gbyte++;
        step();
        bus.sd_valid = 1'b0;
        bus.sd_sector_done = 1'b0;
        if (last && !same) begin
            bus.sd_sector_done = 1'b1;
            step();
            bus.sd_sector_done = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_error"}, {31'd0, error}, 0);
        check({tag, "_sd_start"}, {31'd0, bus.sd_start}, 0);
        check({tag, "_sd_sector"}, bus.sd_sector, 0);
        check({tag, "_fb_we"}, {31'd0, bus.fb_we}, 0);
        check({tag, "_fb_addr"}, {15'd0, bus.fb_addr}, 0);
        check({tag, "_fb_data"}, {24'd0, bus.fb_data}, 0);
    endtask

    // mode: 0 normal, 1 short sector, 2 timeout, 3 reset mid-sector,
    //       4 load_start pulsed mid-load
    task automatic run_load(input int idx, input int mode);
        int d0, nbytes, n;
        bit ok;
        for (int i = 0; i < NPIX * 3; i++) img[i] = 8'($urandom);
        if (idx == 0) begin
            img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hC0;
            img[510] = 8'hE0; img[511] = 8'h1C; img[512] = 8'h03;
        end
        gbyte = 0;
        wr_cnt = 0;
        d0 = done_cnt;
        load_start = 1'b1;
        image_index = 8'(idx);
        step();
        load_start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 1);
        check("error_cleared", {31'd0, error}, 0);
        for (int s = 0; s < SPI; s++) begin
            bus.sd_busy = 1'b1;
            repeat ($urandom_range(0, 3)) step();
            bus.sd_busy = 1'b0;
            exp_sec_q.push_back(BASE + idx * SPI + s);
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (bus.sd_start) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            if (!ok) begin
                check("sd_start_seen", 0, 1);
                return;
            end
            nbytes = (mode == 1 && s == 5) ? 300 : SB;
            for (int b = 0; b < nbytes; b++) begin
                if (mode == 4 && s == 2 && b == 50) begin
                    load_start = 1'b1;
                    image_index = 8'd7;
                    step();
                    load_start = 1'b0;
                    check("busy_mid_load", {31'd0, busy}, 1);
                end
                if (mode == 2 && s == 2 && b == 200) begin
                    n = 0;
                    for (int i = 0; i < 200; i++) begin
                        @(posedge clk);
                        n++;
                        #1;
                        if (error) break;
                    end
                    check("timeout_cycles", n, TMO);
                    check("timeout_busy", {31'd0, busy}, 0);
                    repeat (30) step();
                    check("timeout_no_done", done_cnt, d0);
                    return;
                end
                if (mode == 3 && s == 1 && b == 100) begin
                    step();
                    reset = 1'b1;
                    step();
                    check_idle_outputs("midreset");
                    reset = 1'b0;
                    check("midreset_pix_q", exp_pix_q.size(), 0);
                    repeat (20) step();
                    return;
                end
                drive_byte(img[gbyte], b == nbytes - 1);
            end
            if (mode == 1 && s == 5) begin
                check("short_error", {31'd0, error}, 1);
                check("short_busy", {31'd0, busy}, 0);
                repeat (50) step();
                check("short_no_done", done_cnt, d0);
                check("short_pix_q", exp_pix_q.size(), 0);
                return;
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (done_cnt != d0) break;
            step();
        end
        repeat (5) step();
        check("done_pulses", done_cnt, d0 + 1);
        check("end_error", {31'd0, error}, 0);
        check("end_busy", {31'd0, busy}, 0);
        check("writes", wr_cnt, NPIX);
        check("last_addr", last_addr, NPIX - 1);
        check("pix_q_empty", exp_pix_q.size(), 0);
        check("sec_q_empty", exp_sec_q.size(), 0);
        if (idx == 0) begin
            check("px0_ff", {24'd0, fb_mem[0]}, 32'hFF);
            check("px170_e0", {24'd0, fb_mem[170]}, 32'hE0);
        end
    endtask

    initial begin
        reset = 1'b1;
        load_start = 1'b0;
        image_index = '0;
        bus.sd_busy = 1'b0;
        bus.sd_data = '0;
        bus.sd_valid = 1'b0;
        bus.sd_sector_done = 1'b0;
        repeat (3) step();
        check_idle_outputs("reset");
        reset = 1'b0;
        repeat (3) step();
        run_load(0, 0);
        run_load(2, 4);
        run_load(1, 1);
        run_load(3, 2);
        run_load(4, 3);
        run_load(0, 0);
        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
